pu_layer_param_server: RTL and testbench

Responder side of the PU layer-request interface. The PU controller walks the network one layer at a time and requests that layer's parameter record. This block stores the per-layer records, written by the host configuration port, and answers each request with the record, a last-layer flag and a range-error flag. It uses a valid/ready handshake on both the request and the response channel.

---
 rtl/pu_layer_param_server.sv | 162 ++++++++++++++++
 tb/tb_pu_layer_param_server.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pu_layer_param_server.sv
// pu_layer_param_server
// Responds to PU layer requests with the stored per-layer parameter record,
// a last-layer flag and a range-error flag. The host writes the layer table
// and the layer count through the configuration port at any time.
module pu_layer_param_server #(
  parameter int LAYER_PARAM_WIDTH = 10,
  parameter int MAX_LAYERS        = 64,
  parameter int LAYER_ADDR_W      = 6
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cfg_wr_en,
  input  logic [LAYER_ADDR_W-1:0]        cfg_wr_addr,
  input  logic [4*LAYER_PARAM_WIDTH-1:0] cfg_wr_data,
  input  logic                           cfg_num_layers_we,
  input  logic [LAYER_PARAM_WIDTH-1:0]   cfg_num_layers,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [LAYER_ADDR_W-1:0]        req_layer,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [4*LAYER_PARAM_WIDTH-1:0] rsp_params,
  output logic                           rsp_last,
  output logic                           rsp_err,
  output logic                           busy,
  output logic [LAYER_PARAM_WIDTH-1:0]   rsp_count
);

  localparam int REC_W = 4 * LAYER_PARAM_WIDTH;
  localparam logic [LAYER_PARAM_WIDTH-1:0] MAX_LAYERS_V = LAYER_PARAM_WIDTH'(MAX_LAYERS);
  localparam logic [LAYER_PARAM_WIDTH-1:0] ONE_V        = LAYER_PARAM_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [REC_W-1:0]             layer_table [MAX_LAYERS];
  logic [LAYER_PARAM_WIDTH-1:0] num_layers;
  logic [LAYER_PARAM_WIDTH-1:0] num_eff;
  logic [LAYER_PARAM_WIDTH-1:0] req_layer_ext;
  logic                         req_err_now;
  logic                         req_last_now;
  logic                         accept;
  logic                         handshake;
  logic [LAYER_ADDR_W-1:0]      lat_layer;
  logic                         lat_err;
  logic                         lat_last;

  assign accept        = (state == IDLE) && req_valid;
  assign handshake     = (state == RESP) && rsp_ready;
  assign req_ready     = (state == IDLE);
  assign busy          = (state != IDLE);
  assign rsp_valid     = (state == RESP);
  assign req_layer_ext = LAYER_PARAM_WIDTH'(req_layer);

  // Clamp the layer count to the table depth and classify the incoming index.
  always_comb begin
    num_eff      = num_layers;
    req_err_now  = 1'b1;
    req_last_now = 1'b0;
    if (num_layers > MAX_LAYERS_V) begin
      num_eff = MAX_LAYERS_V;
    end else begin
      num_eff = num_layers;
    end
    req_err_now = (req_layer_ext >= num_eff);
    if (!req_err_now) begin
      req_last_now = (req_layer_ext == (num_eff - ONE_V));
    end else begin
      req_last_now = 1'b0;
    end
  end

  // Next-state logic for the request/response sequencer.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_next = READ;
        end else begin
          state_next = IDLE;
        end
      end
      READ: state_next = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end else begin
          state_next = RESP;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Layer table; contents survive reset, and a same-cycle write is seen only by later reads.
  always_ff @(posedge clk) begin
    if (cfg_wr_en) begin
      layer_table[cfg_wr_addr] <= cfg_wr_data;
    end
  end

  // Layer count register; a request accepted in the same cycle still sees the old count.
  always_ff @(posedge clk) begin
    if (reset) begin
      num_layers <= '0;
    end else if (cfg_num_layers_we) begin
      num_layers <= cfg_num_layers;
    end
  end

  // Capture the request index and its range/last classification on acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_layer <= '0;
      lat_err   <= 1'b0;
      lat_last  <= 1'b0;
    end else if (accept) begin
      lat_layer <= req_layer;
      lat_err   <= req_err_now;
      lat_last  <= req_last_now;
    end
  end

  // Load the response registers at the end of the READ cycle; hold them otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_params <= '0;
      rsp_last   <= 1'b0;
      rsp_err    <= 1'b0;
    end else if (state == READ) begin
      rsp_params <= lat_err ? '0 : layer_table[lat_layer];
      rsp_last   <= lat_last;
      rsp_err    <= lat_err;
    end
  end

  // Count completed response handshakes, wrapping naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_count <= '0;
    end else if (handshake) begin
      rsp_count <= rsp_count + ONE_V;
    end
  end

endmodule

// File: tb/tb_pu_layer_param_server.sv
// Directed self-checking bench for pu_layer_param_server.
module tb_pu_layer_param_server;

  localparam int PW = 10;
  localparam int AW = 6;
  localparam int RW = 4 * PW;

  logic          clk;
  logic          reset;
  logic          cfg_wr_en;
  logic [AW-1:0] cfg_wr_addr;
  logic [RW-1:0] cfg_wr_data;
  logic          cfg_num_layers_we;
  logic [PW-1:0] cfg_num_layers;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_layer;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [RW-1:0] rsp_params;
  logic          rsp_last;
  logic          rsp_err;
  logic          busy;
  logic [PW-1:0] rsp_count;

  int checks = 0;
  int errors = 0;
  int exp_count = 0;

  pu_layer_param_server #(
    .LAYER_PARAM_WIDTH(PW),
    .MAX_LAYERS(64),
    .LAYER_ADDR_W(AW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cfg_wr_en(cfg_wr_en),
    .cfg_wr_addr(cfg_wr_addr),
    .cfg_wr_data(cfg_wr_data),
    .cfg_num_layers_we(cfg_num_layers_we),
    .cfg_num_layers(cfg_num_layers),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_layer(req_layer),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_params(rsp_params),
    .rsp_last(rsp_last),
    .rsp_err(rsp_err),
    .busy(busy),
    .rsp_count(rsp_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [RW-1:0] rec(input int in_ch, input int out_ch, input int kernel, input int stride);
    rec = {PW'(in_ch), PW'(out_ch), PW'(kernel), PW'(stride)};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input int addr, input logic [RW-1:0] data);
    cfg_wr_en   = 1'b1;
    cfg_wr_addr = AW'(addr);
    cfg_wr_data = data;
    @(posedge clk); #1;
    cfg_wr_en = 1'b0;
  endtask

  task automatic set_layers(input int n);
    cfg_num_layers_we = 1'b1;
    cfg_num_layers    = PW'(n);
    @(posedge clk); #1;
    cfg_num_layers_we = 1'b0;
  endtask

  // Present a request and return #1 after its acceptance edge (READ cycle).
  task automatic req_start(input int layer);
    check("req_ready_before", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_layer = AW'(layer);
    @(posedge clk); #1;
    req_valid         = 1'b0;
    cfg_num_layers_we = 1'b0;
    check("rsp_valid_in_read", 64'(rsp_valid), 64'd0);
    check("busy_in_read", 64'(busy), 64'd1);
  endtask

  // Check the response, optionally stall, then complete the handshake.
  task automatic req_finish(input logic [RW-1:0] ep, input logic el, input logic ee, input int stall);
    @(posedge clk); #1;
    cfg_wr_en = 1'b0;
    check("rsp_valid", 64'(rsp_valid), 64'd1);
    check("rsp_params", 64'(rsp_params), 64'(ep));
    check("rsp_last", 64'(rsp_last), 64'(el));
    check("rsp_err", 64'(rsp_err), 64'(ee));
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check("stall_valid", 64'(rsp_valid), 64'd1);
      check("stall_params", 64'(rsp_params), 64'(ep));
      check("stall_req_ready", 64'(req_ready), 64'd0);
      check("stall_busy", 64'(busy), 64'd1);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    exp_count = (exp_count + 1) % 1024;
    check("post_hs_valid", 64'(rsp_valid), 64'd0);
    check("post_hs_req_ready", 64'(req_ready), 64'd1);
    check("rsp_count", 64'(rsp_count), 64'(exp_count));
    check("post_hs_params_held", 64'(rsp_params), 64'(ep));
  endtask

  initial begin
    reset = 1'b1;
    cfg_wr_en = 1'b0;
    cfg_wr_addr = '0;
    cfg_wr_data = '0;
    cfg_num_layers_we = 1'b0;
    cfg_num_layers = '0;
    req_valid = 1'b0;
    req_layer = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_count", 64'(rsp_count), 64'd0);
    check("rst_rsp_params", 64'(rsp_params), 64'd0);
    check("rst_rsp_last", 64'(rsp_last), 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);

    // Table setup.
    cfg_write(3, rec(16, 32, 3, 1));
    cfg_write(4, rec(8, 8, 1, 2));
    cfg_write(2, rec(1, 2, 3, 4));
    cfg_write(63, rec(5, 6, 7, 1));
    set_layers(5);

    // Basic read, last layer, out of range.
    req_start(3); req_finish(rec(16, 32, 3, 1), 1'b0, 1'b0, 0);
    req_start(4); req_finish(rec(8, 8, 1, 2), 1'b1, 1'b0, 0);
    req_start(5); req_finish('0, 1'b0, 1'b1, 0);

    // Backpressure for 10 cycles.
    req_start(3); req_finish(rec(16, 32, 3, 1), 1'b0, 1'b0, 10);

    // Write to table[2] during its READ cycle: old data now, new data next time.
    req_start(2);
    cfg_wr_en = 1'b1; cfg_wr_addr = AW'(2); cfg_wr_data = rec(9, 9, 9, 9);
    req_finish(rec(1, 2, 3, 4), 1'b0, 1'b0, 0);
    req_start(2); req_finish(rec(9, 9, 9, 9), 1'b0, 1'b0, 0);

    // Count update in the acceptance cycle uses the old count; later requests see the new one.
    cfg_num_layers_we = 1'b1; cfg_num_layers = PW'(10);
    req_start(4); req_finish(rec(8, 8, 1, 2), 1'b1, 1'b0, 0);
    req_start(4); req_finish(rec(8, 8, 1, 2), 1'b0, 1'b0, 0);

    // Count above the table depth is clamped: layer 63 is the last one.
    set_layers(100);
    req_start(63); req_finish(rec(5, 6, 7, 1), 1'b1, 1'b0, 0);

    // Zero layers: every request errors.
    set_layers(0);
    req_start(0); req_finish('0, 1'b0, 1'b1, 0);

    // Reset while the response is pending.
    set_layers(5);
    req_start(3);
    @(posedge clk); #1;
    check("pre_reset_valid", 64'(rsp_valid), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_count = 0;
    check("rr_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rr_req_ready", 64'(req_ready), 64'd1);
    check("rr_rsp_count", 64'(rsp_count), 64'd0);

    // Layer count was cleared by reset, so layer 0 now errors.
    req_start(0); req_finish('0, 1'b0, 1'b1, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_count = 0;

    // 1030 back-to-back requests, 3 cycles apiece, count wraps to 6.
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_layer = '0;
    repeat (3090) @(posedge clk);
    #1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    check("wrap_rsp_count", 64'(rsp_count), 64'd6);
    check("wrap_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    check("wrap_idle_valid", 64'(rsp_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
